// File: rtl/qsys_cpu_oci_dct_sequencer.sv
// qsys_cpu_oci_dct_sequencer: packs 2-bit trace frames into a 30-bit DCT buffer,
// hands full or flushed buffers to the sink and sequences end-of-test.
module qsys_cpu_oci_dct_sequencer #(
    parameter int FRAME_W = 2,
    parameter int DEPTH   = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_valid,
    input  logic [FRAME_W-1:0]         frame_data,
    output logic                       frame_ready,
    input  logic                       test_ending,
    output logic [DEPTH*FRAME_W-1:0]   dct_buffer,
    output logic [3:0]                 dct_count,
    output logic                       dct_valid,
    input  logic                       dct_ready,
    output logic                       test_has_ended
);
    typedef enum logic [1:0] {FILL, HOLD, ENDED} state_t;

    state_t                     state, state_n;
    logic [DEPTH*FRAME_W-1:0]   buf_n;
    logic [3:0]                 cnt_n;
    logic                       flush_pending, fp_n;
    logic                       accept;

    assign frame_ready = (state == FILL);
    assign accept      = frame_valid & frame_ready;

    always_comb begin
        state_n = state;
        buf_n   = dct_buffer;
        cnt_n   = dct_count;
        fp_n    = flush_pending;
        case (state)
            FILL: begin
                if (accept) begin
                    buf_n = dct_buffer | ((DEPTH*FRAME_W)'(frame_data) << (dct_count * FRAME_W));
                    cnt_n = dct_count + 4'd1;
                end
                // a frame taken alongside a flush is included in the flushed buffer
                if (test_ending | flush_pending) begin
                    state_n = (cnt_n != 4'd0) ? HOLD : ENDED;
                    fp_n    = (cnt_n != 4'd0);
                end else if (cnt_n == 4'(DEPTH)) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                fp_n = flush_pending | test_ending;
                if (dct_ready) begin
                    buf_n   = '0;
                    cnt_n   = 4'd0;
                    state_n = fp_n ? ENDED : FILL;
                end
            end
            default: begin
                buf_n = '0;
                cnt_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FILL;
            dct_buffer     <= '0;
            dct_count      <= 4'd0;
            flush_pending  <= 1'b0;
            dct_valid      <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            state          <= state_n;
            dct_buffer     <= buf_n;
            dct_count      <= cnt_n;
            flush_pending  <= fp_n;
            dct_valid      <= (state_n == HOLD);
            test_has_ended <= (state_n == ENDED);
        end
    end
endmodule

// File: tb/tb_qsys_cpu_oci_dct_sequencer.sv
// tb_qsys_cpu_oci_dct_sequencer: directed vectors plus a frame-queue model checked every cycle.
module tb_qsys_cpu_oci_dct_sequencer;
    logic        clk = 0;
    logic        reset = 1;
    logic        frame_valid = 0;
    logic [1:0]  frame_data = 0;
    logic        frame_ready;
    logic        test_ending = 0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready = 0;
    logic        test_has_ended;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    qsys_cpu_oci_dct_sequencer dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
        .frame_ready(frame_ready), .test_ending(test_ending), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .dct_valid(dct_valid), .dct_ready(dct_ready),
        .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: the buffer is just the list of frames taken so far
    logic [1:0] mq[$];
    bit m_pres = 0, m_pend = 0, m_end = 0;

    function automatic logic [29:0] packed_frames();
        logic [29:0] v = '0;
        foreach (mq[k]) v[2*k +: 2] = mq[k];
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_pres = 0; m_pend = 0; m_end = 0;
        end else if (m_end) begin
        end else if (m_pres) begin
            m_pend = m_pend | test_ending;
            if (dct_ready) begin
                mq.delete();
                m_pres = 0;
                m_end = m_pend;
            end
        end else begin
            if (frame_valid) mq.push_back(frame_data);
            if (test_ending || m_pend) begin
                if (mq.size() > 0) begin m_pres = 1; m_pend = 1; end
                else m_end = 1;
            end else if (mq.size() == 15) m_pres = 1;
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("m_frame_ready", 32'(frame_ready), 32'(!m_pres && !m_end));
        check("m_dct_valid", 32'(dct_valid), 32'(m_pres));
        check("m_dct_count", 32'(dct_count), 32'(mq.size()));
        check("m_dct_buffer", 32'(dct_buffer), 32'(packed_frames()));
        check("m_test_has_ended", 32'(test_has_ended), 32'(m_end));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1; frame_valid = 0; test_ending = 0; dct_ready = 0;
        tick();
        reset = 0;
    endtask

    task automatic push(input logic [1:0] d);
        frame_valid = 1; frame_data = d; tick(); frame_valid = 0;
    endtask

    initial begin
        tick(2);
        reset = 0;
        chk_en = 1;
        check("rst_frame_ready", 32'(frame_ready), 1);
        check("rst_count", 32'(dct_count), 0);
        check("rst_valid", 32'(dct_valid), 0);

        // full buffer with a ready sink
        dct_ready = 1;
        for (int k = 0; k < 15; k++) push(2'(k % 4));
        check("fill_valid", 32'(dct_valid), 1);
        check("fill_count", 32'(dct_count), 15);
        check("fill_buffer", 32'(dct_buffer), 32'h24E4E4E4);
        tick();
        check("fill_after_count", 32'(dct_count), 0);
        check("fill_after_ready", 32'(frame_ready), 1);

        // backpressure with the source still offering frames
        dct_ready = 0;
        frame_valid = 1;
        for (int k = 0; k < 15; k++) begin frame_data = 2'(k % 4); tick(); end
        frame_data = 2'b10;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_frame_ready", 32'(frame_ready), 0);
            check("bp_buffer", 32'(dct_buffer), 32'h24E4E4E4);
            check("bp_count", 32'(dct_count), 15);
        end
        dct_ready = 1;
        tick();
        tick();
        frame_valid = 0;
        check("bp_16th_count", 32'(dct_count), 1);
        check("bp_16th_buffer", 32'(dct_buffer), 2);

        // reset mid-fill
        for (int k = 0; k < 6; k++) push(2'b01);
        check("mid_count", 32'(dct_count), 7);
        do_reset();
        check("mid_rst_count", 32'(dct_count), 0);
        check("mid_rst_buffer", 32'(dct_buffer), 0);
        check("mid_rst_valid", 32'(dct_valid), 0);
        check("mid_rst_ended", 32'(test_has_ended), 0);
        check("mid_rst_ready", 32'(frame_ready), 1);

        // partial flush
        push(2'b11); push(2'b01); push(2'b10);
        test_ending = 1; tick(); test_ending = 0;
        check("pf_valid", 32'(dct_valid), 1);
        check("pf_count", 32'(dct_count), 3);
        check("pf_buffer", 32'(dct_buffer), 32'h027);
        tick(2);
        dct_ready = 1; tick(); dct_ready = 0;
        check("pf_ended", 32'(test_has_ended), 1);
        check("pf_frame_ready", 32'(frame_ready), 0);
        test_ending = 1; tick(3); test_ending = 0;
        check("pf_sticky", 32'(test_has_ended), 1);
        do_reset();

        // frame and flush in the same cycle
        for (int k = 0; k < 4; k++) push(2'(k));
        frame_valid = 1; frame_data = 2'b10; test_ending = 1;
        tick();
        frame_valid = 0; test_ending = 0;
        check("sim_valid", 32'(dct_valid), 1);
        check("sim_count", 32'(dct_count), 5);
        check("sim_bits98", 32'(dct_buffer[9:8]), 2);
        dct_ready = 1; tick(); dct_ready = 0;
        check("sim_ended", 32'(test_has_ended), 1);
        do_reset();

        // empty flush
        test_ending = 1; tick(); test_ending = 0;
        check("ef_ended", 32'(test_has_ended), 1);
        check("ef_valid", 32'(dct_valid), 0);
        tick(2);
        do_reset();

        // flush arriving while a full buffer is held
        for (int k = 0; k < 15; k++) push(2'(3 - k % 4));
        tick();
        test_ending = 1; tick(); test_ending = 0;
        tick(2);
        check("fh_valid", 32'(dct_valid), 1);
        dct_ready = 1; tick(); dct_ready = 0;
        check("fh_ended", 32'(test_has_ended), 1);
        check("fh_frame_ready", 32'(frame_ready), 0);
        check("fh_valid_after", 32'(dct_valid), 0);
        do_reset();

        // random traffic, model-checked only
        for (int k = 0; k < 300; k++) begin
            frame_valid = 1'($urandom_range(0, 1));
            frame_data = 2'($urandom_range(0, 3));
            dct_ready = ($urandom_range(0, 3) != 0);
            test_ending = ($urandom_range(0, 60) == 0);
            tick();
        end
        frame_valid = 0; test_ending = 0; dct_ready = 0;
        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
